// File: rtl/univ_shift_reg.sv
// univ_shift_reg: parametrised universal shift register.
//
// A WIDTH-bit register that can hold, shift right, shift left or parallel load.
// It has serial inputs and outputs at both ends plus a parallel output. A shift
// counter emits a one-cycle word_done pulse after every WIDTH shifts. Serial links
// and bit-serial datapaths use it as a SIPO, PISO or SISO element.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   en           1 = apply mode this cycle, 0 = hold everything
//   mode         00 hold, 01 shift right, 10 shift left, 11 parallel load
//   ser_in_msb   serial input entering bit WIDTH-1 on shift right
//   ser_in_lsb   serial input entering bit 0 on shift left
//   par_in       parallel load data
//   par_out      current register contents
//   ser_out_lsb  q[0], serial output for shift right
//   ser_out_msb  q[WIDTH-1], serial output for shift left
//   shift_cnt    shifts performed since the last load or wrap
//   word_done    registered one-cycle pulse when WIDTH shifts complete

module univ_shift_reg #(
   parameter int unsigned      WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic [1:0]               mode,
   input  logic                     ser_in_msb,
   input  logic                     ser_in_lsb,
   input  logic [WIDTH-1:0]         par_in,
   output logic [WIDTH-1:0]         par_out,
   output logic                     ser_out_lsb,
   output logic                     ser_out_msb,
   output logic [$clog2(WIDTH)-1:0] shift_cnt,
   output logic                     word_done
);

   localparam int unsigned     CntW   = $clog2(WIDTH);
   localparam logic [CntW-1:0] CntMax = CntW'(WIDTH - 1);

   logic [WIDTH-1:0] q_q, q_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             done_q, done_d;
   logic             shifting;

   always_comb begin
      q_d      = q_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;
      shifting = 1'b0;
      if (en) begin
         unique case (mode)
            2'b01: begin
               q_d      = {ser_in_msb, q_q[WIDTH-1:1]};
               shifting = 1'b1;
            end
            2'b10: begin
               q_d      = {q_q[WIDTH-2:0], ser_in_lsb};
               shifting = 1'b1;
            end
            2'b11: begin
               // Load aborts any partial word: counter restarts, no pulse.
               q_d   = par_in;
               cnt_d = '0;
            end
            default: ;
         endcase
      end
      // Counter is direction-agnostic; wrap generates the word pulse.
      if (shifting) begin
         if (cnt_q == CntMax) begin
            cnt_d  = '0;
            done_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q_q    <= RESET_VAL;
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         q_q    <= q_d;
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end

   assign par_out     = q_q;
   assign ser_out_lsb = q_q[0];
   assign ser_out_msb = q_q[WIDTH-1];
   assign shift_cnt   = cnt_q;
   assign word_done   = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg: self-checking bench for univ_shift_reg.
// A behavioural model tracks the register value and the total number of shifts
// since the last load/reset. From that total it derives the count and the word pulse.

module tb_univ_shift_reg;

   localparam int unsigned      WIDTH     = 8;
   localparam int unsigned      CW        = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] RESET_VAL = WIDTH'(32'h5A5A_5A5A);

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             en = 1'b0;
   logic [1:0]       mode = 2'b00;
   logic             ser_in_msb = 1'b0;
   logic             ser_in_lsb = 1'b0;
   logic [WIDTH-1:0] par_in = '0;
   logic [WIDTH-1:0] par_out;
   logic             ser_out_lsb;
   logic             ser_out_msb;
   logic [CW-1:0]    shift_cnt;
   logic             word_done;

   univ_shift_reg #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .mode        (mode),
      .ser_in_msb  (ser_in_msb),
      .ser_in_lsb  (ser_in_lsb),
      .par_in      (par_in),
      .par_out     (par_out),
      .ser_out_lsb (ser_out_lsb),
      .ser_out_msb (ser_out_msb),
      .shift_cnt   (shift_cnt),
      .word_done   (word_done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state.
   logic [WIDTH-1:0] m_q = RESET_VAL;
   int               m_shifts = 0;
   logic             m_done = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, "/par_out"}, 64'(par_out), 64'(m_q));
      chk({tag, "/ser_out_lsb"}, 64'(ser_out_lsb), 64'(m_q[0]));
      chk({tag, "/ser_out_msb"}, 64'(ser_out_msb), 64'(m_q[WIDTH-1]));
      chk({tag, "/shift_cnt"}, 64'(shift_cnt), 64'(m_shifts % WIDTH));
      chk({tag, "/word_done"}, 64'(word_done), 64'(m_done));
   endtask

   task automatic model_step(input logic e, input logic [1:0] md, input logic sm,
                             input logic sl, input logic [WIDTH-1:0] pi);
      m_done = 1'b0;
      if (e) begin
         if (md == 2'b01) begin
            m_q = m_q >> 1;
            m_q[WIDTH-1] = sm;
         end else if (md == 2'b10) begin
            m_q = m_q << 1;
            m_q[0] = sl;
         end else if (md == 2'b11) begin
            m_q = pi;
            m_shifts = 0;
         end
         if (md == 2'b01 || md == 2'b10) begin
            m_shifts++;
            m_done = (m_shifts % WIDTH == 0);
         end
      end
   endtask

   // One clock: apply inputs, clock, update model, check #1 after the edge.
   task automatic cycle(input string tag, input logic e, input logic [1:0] md, input logic sm,
                        input logic sl, input logic [WIDTH-1:0] pi);
      en = e; mode = md; ser_in_msb = sm; ser_in_lsb = sl; par_in = pi;
      @(posedge clk);
      model_step(e, md, sm, sl, pi);
      #1;
      check_all(tag);
   endtask

   // Assert reset mid-cycle; outputs must clear before any clock edge.
   task automatic reset_mid(input string tag);
      #3;
      rst = 1'b0;
      #1;
      m_q = RESET_VAL; m_shifts = 0; m_done = 1'b0;
      check_all({tag, "_async"});
      @(posedge clk);
      #1;
      check_all({tag, "_held"});
      #3;
      rst = 1'b1;
   endtask

   function automatic logic [WIDTH-1:0] rnd_word();
      return WIDTH'({$urandom, $urandom});
   endfunction

   initial begin
      logic             pat [8];
      logic [WIDTH-1:0] ld;
      logic [WIDTH-1:0] frozen;
      logic [CW-1:0]    frozen_cnt;
      int               pulses;

      pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

      // Power-on reset.
      repeat (2) @(posedge clk);
      #1;
      check_all("por");
      #3;
      rst = 1'b1;

      // Load A5, then async reset mid-cycle.
      cycle("load_a5", 1'b1, 2'b11, 1'b0, 1'b0, WIDTH'(8'hA5));
      reset_mid("rst_a5");

      // Reset one shift before a wrap: the pending pulse is lost.
      cycle("pre_load", 1'b1, 2'b11, 1'b0, 1'b0, rnd_word());
      for (int i = 0; i < WIDTH - 1; i++)
         cycle("pre_wrap", 1'b1, 2'b01, 1'($urandom), 1'($urandom), rnd_word());
      reset_mid("rst_wrap");
      cycle("after_rst", 1'b1, 2'b10, 1'($urandom), 1'($urandom), rnd_word());
      chk("after_rst_cnt", 64'(shift_cnt), 64'(1));

      // SISO right: pattern reappears on ser_out_lsb after WIDTH shifts.
      cycle("siso_load", 1'b1, 2'b11, 1'b0, 1'b0, '0);
      for (int n = 1; n <= 2 * WIDTH; n++) begin
         cycle("siso", 1'b1, 2'b01, (n <= WIDTH) ? pat[(n - 1) % 8] : 1'b0, 1'($urandom),
               rnd_word());
         if (n >= WIDTH && n < 2 * WIDTH)
            chk("siso_latency", 64'(ser_out_lsb), 64'(pat[(n - WIDTH) % 8]));
         chk("siso_done", 64'(word_done), 64'(n % WIDTH == 0));
      end

      // PISO: load C3, shift left with zero fill.
      ld = WIDTH'(8'hC3);
      cycle("piso_load", 1'b1, 2'b11, 1'b0, 1'b0, ld);
      pulses = 0;
      for (int k = 0; k < WIDTH; k++) begin
         chk("piso_msb", 64'(ser_out_msb), 64'(ld[WIDTH-1-k]));
         cycle("piso", 1'b1, 2'b10, 1'($urandom), 1'b0, rnd_word());
         if (word_done) pulses++;
      end
      chk("piso_empty", 64'(par_out), 64'(0));
      chk("piso_pulses", 64'(pulses), 64'(1));

      // Hold / enable: 3 shifts, 4 disabled cycles, remaining shifts.
      cycle("hold_load", 1'b1, 2'b11, 1'b0, 1'b0, rnd_word());
      for (int i = 0; i < 3; i++)
         cycle("hold_pre", 1'b1, 2'($urandom_range(1, 2)), 1'($urandom), 1'($urandom),
               rnd_word());
      frozen     = par_out;
      frozen_cnt = shift_cnt;
      for (int i = 0; i < 4; i++) begin
         cycle("hold_off", 1'b0, 2'($urandom), 1'($urandom), 1'($urandom), rnd_word());
         chk("hold_q", 64'(par_out), 64'(frozen));
         chk("hold_cnt", 64'(shift_cnt), 64'(frozen_cnt));
      end
      for (int i = 0; i < 5; i++)
         cycle("hold_post", 1'b1, 2'($urandom_range(1, 2)), 1'($urandom), 1'($urandom),
               rnd_word());

      // Abort: 5 shifts then load 0F.
      for (int i = 0; i < 5; i++)
         cycle("abort_shift", 1'b1, 2'b01, 1'($urandom), 1'($urandom), rnd_word());
      cycle("abort_load", 1'b1, 2'b11, 1'b0, 1'b0, WIDTH'(8'h0F));
      chk("abort_cnt", 64'(shift_cnt), 64'(0));
      chk("abort_done", 64'(word_done), 64'(0));

      // Direction change mid-word: 4 right then 4 left.
      for (int i = 0; i < 8; i++)
         cycle("dir_chg", 1'b1, (i < 4) ? 2'b01 : 2'b10, 1'($urandom), 1'($urandom),
               rnd_word());

      // Continuous shifting: pulses every WIDTH shifts with no gap.
      cycle("cont_load", 1'b1, 2'b11, 1'b0, 1'b0, rnd_word());
      pulses = 0;
      for (int i = 0; i < 24; i++) begin
         cycle("cont", 1'b1, 2'($urandom_range(1, 2)), 1'($urandom), 1'($urandom), rnd_word());
         if (word_done) pulses++;
      end
      chk("cont_pulses", 64'(pulses), 64'(24 / WIDTH));

      // Random traffic against the model.
      for (int i = 0; i < 300; i++)
         cycle("rand", 1'($urandom_range(0, 3) != 0), 2'($urandom), 1'($urandom),
               1'($urandom), rnd_word());

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
